// File: rtl/id_pkg.sv
// Shared decode constants for the instruction-decode stage: opcodes, funct codes,
// the 4-bit ALU control encoding and the funct-to-ALU lookup.
package id_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_FPR   = 6'h11;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_LWC1  = 6'h31;
  localparam logic [5:0] OP_SWC1  = 6'h39;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  localparam logic [5:0] FN_FADD = 6'h00;
  localparam logic [5:0] FN_FSUB = 6'h01;
  localparam logic [5:0] FN_FMUL = 6'h02;
  localparam logic [5:0] FN_FDIV = 6'h03;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9,
    ALU_FADD = 4'd10,
    ALU_FSUB = 4'd11,
    ALU_FMUL = 4'd12,
    ALU_FDIV = 4'd13
  } alu_ctrl_e;

  typedef struct packed {
    logic [3:0] alu;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       branch;
    logic       jump;
  } ctrl_t;

  // Unknown funct codes fall back to an add so a bad encoding is harmless.
  function automatic alu_ctrl_e funct_to_alu(input logic fp, input logic [5:0] funct);
    alu_ctrl_e a;
    a = ALU_ADD;
    if (fp) begin
      case (funct)
        FN_FADD: a = ALU_FADD;
        FN_FSUB: a = ALU_FSUB;
        FN_FMUL: a = ALU_FMUL;
        FN_FDIV: a = ALU_FDIV;
        default: a = ALU_FADD;
      endcase
    end else begin
      case (funct)
        FN_ADD, FN_ADDU: a = ALU_ADD;
        FN_SUB, FN_SUBU: a = ALU_SUB;
        FN_AND:          a = ALU_AND;
        FN_OR:           a = ALU_OR;
        FN_XOR:          a = ALU_XOR;
        FN_NOR:          a = ALU_NOR;
        FN_SLT:          a = ALU_SLT;
        FN_SLL:          a = ALU_SLL;
        FN_SRL:          a = ALU_SRL;
        FN_SRA:          a = ALU_SRA;
        default:         a = ALU_ADD;
      endcase
    end
    return a;
  endfunction

endpackage

// File: rtl/id_regbank.sv
// One register bank: NREG x XLEN, two read ports, one write port and a debug read
// port. Reads are combinational with a same-cycle write forwarded (write-first).
module id_regbank #(
  parameter int XLEN    = 32,
  parameter int NREG    = 32,
  parameter bit ZERO_R0 = 1'b1,
  localparam int AW     = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_we,
  input  logic [AW-1:0]   i_waddr,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [AW-1:0]   i_raddr1,
  output logic [XLEN-1:0] o_rdata1,
  input  logic [AW-1:0]   i_raddr2,
  output logic [XLEN-1:0] o_rdata2,
  input  logic [AW-1:0]   i_dbg_addr,
  output logic [XLEN-1:0] o_dbg_data
);

  logic [XLEN-1:0] r_mem [NREG];

  function automatic logic [XLEN-1:0] rd_port(input logic [AW-1:0]   a,
                                               input logic [XLEN-1:0] stored,
                                               input logic            we,
                                               input logic [AW-1:0]   wa,
                                               input logic [XLEN-1:0] wd);
    if (ZERO_R0 && a == '0) return '0;
    else if (we && wa == a) return wd;
    else return stored;
  endfunction

  assign o_rdata1   = rd_port(i_raddr1,   r_mem[i_raddr1],   i_we, i_waddr, i_wdata);
  assign o_rdata2   = rd_port(i_raddr2,   r_mem[i_raddr2],   i_we, i_waddr, i_wdata);
  assign o_dbg_data = rd_port(i_dbg_addr, r_mem[i_dbg_addr], i_we, i_waddr, i_wdata);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
    end else if (i_we && !(ZERO_R0 && i_waddr == '0)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

endmodule

// File: rtl/id_stage_param.sv
// Instruction-decode stage: decodes the offered instruction, reads the integer/FP
// register banks, interlocks on load-use hazards and registers the result into D/X.
module id_stage_param
  import id_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int NBANK  = 2,
  parameter int HAZ_EN = 1,
  localparam int AW    = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [XLEN-1:0] if_pc,
  input  logic [31:0]     if_instr,
  input  logic            wb_en,
  input  logic            wb_bank,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  input  logic            ex_ready,
  output logic            dx_valid,
  output logic [XLEN-1:0] dx_pc,
  output logic [XLEN-1:0] dx_src1,
  output logic [XLEN-1:0] dx_src2,
  output logic [XLEN-1:0] dx_store_data,
  output logic [XLEN-1:0] dx_imm,
  output logic [XLEN-1:0] dx_jump_addr,
  output logic [AW-1:0]   dx_rd_addr,
  output logic            dx_bank,
  output logic [3:0]      dx_alu_ctrl,
  output logic            dx_mem_read,
  output logic            dx_mem_write,
  output logic            dx_reg_write,
  output logic            dx_mem_to_reg,
  output logic            dx_branch,
  output logic            dx_jump,
  input  logic            dbg_bank,
  input  logic [AW-1:0]   dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  // Handshake: an instruction moves IF->ID on a cycle with if_valid & if_ready, and
  // ID->EX on a cycle with dx_valid & ex_ready; neither valid may depend on its ready.

  logic [5:0]      w_op, w_funct;
  logic [AW-1:0]   w_rs, w_rt, w_rd, w_dst;
  logic            w_dst_bank, w_rs_bank, w_rt_bank, w_use_rs, w_use_rt;
  ctrl_t           w_ctrl;
  logic [1:0]      w_we;
  logic [XLEN-1:0] w_rd1 [2];
  logic [XLEN-1:0] w_rd2 [2];
  logic [XLEN-1:0] w_dbg [2];
  logic            w_haz_rs, w_haz_rt, w_hazard, w_accept;

  logic            r_valid, r_bank;
  logic [XLEN-1:0] r_pc, r_src1, r_src2, r_store, r_imm, r_jaddr;
  logic [AW-1:0]   r_rd;
  ctrl_t           r_ctrl;

  assign w_op    = if_instr[31:26];
  assign w_funct = if_instr[5:0];
  assign w_rs    = if_instr[21 +: AW];
  assign w_rt    = if_instr[16 +: AW];
  assign w_rd    = if_instr[11 +: AW];

  always_comb begin
    w_ctrl     = '0;
    w_dst      = w_rt;
    w_dst_bank = 1'b0;
    w_rs_bank  = 1'b0;
    w_rt_bank  = 1'b0;
    w_use_rs   = 1'b0;
    w_use_rt   = 1'b0;
    case (w_op)
      OP_RTYPE: begin
        w_ctrl.alu = funct_to_alu(1'b0, w_funct);
        w_ctrl.reg_write = 1'b1;
        w_dst = w_rd;
        w_use_rs = 1'b1;
        w_use_rt = 1'b1;
      end
      OP_ADDI: begin
        w_ctrl.reg_write = 1'b1;
        w_use_rs = 1'b1;
      end
      OP_LW: begin
        w_ctrl.mem_read = 1'b1;
        w_ctrl.reg_write = 1'b1;
        w_ctrl.mem_to_reg = 1'b1;
        w_use_rs = 1'b1;
      end
      OP_SW: begin
        w_ctrl.mem_write = 1'b1;
        w_use_rs = 1'b1;
        w_use_rt = 1'b1;
      end
      OP_BEQ: begin
        w_ctrl.alu = ALU_SUB;
        w_ctrl.branch = 1'b1;
        w_use_rs = 1'b1;
        w_use_rt = 1'b1;
      end
      OP_J: w_ctrl.jump = 1'b1;
      // FP opcodes exist only with a second bank; otherwise they fall to NOP.
      OP_FPR: if (NBANK == 2) begin
        w_ctrl.alu = funct_to_alu(1'b1, w_funct);
        w_ctrl.reg_write = 1'b1;
        w_dst = w_rd;
        w_dst_bank = 1'b1;
        w_rs_bank = 1'b1;
        w_rt_bank = 1'b1;
        w_use_rs = 1'b1;
        w_use_rt = 1'b1;
      end
      OP_LWC1: if (NBANK == 2) begin
        w_ctrl.mem_read = 1'b1;
        w_ctrl.reg_write = 1'b1;
        w_ctrl.mem_to_reg = 1'b1;
        w_dst_bank = 1'b1;
        w_use_rs = 1'b1;
      end
      OP_SWC1: if (NBANK == 2) begin
        w_ctrl.mem_write = 1'b1;
        w_dst_bank = 1'b1;
        w_rt_bank = 1'b1;
        w_use_rs = 1'b1;
        w_use_rt = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset outranks write-back, including the read bypass.
  assign w_we[0] = wb_en & ~rst & ~wb_bank;
  assign w_we[1] = wb_en & ~rst &  wb_bank;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    if (b < NBANK) begin : g_inst
      id_regbank #(.XLEN(XLEN), .NREG(NREG), .ZERO_R0(b == 0)) u_bank (
        .clk        (clk),
        .rst        (rst),
        .i_we       (w_we[b]),
        .i_waddr    (wb_addr),
        .i_wdata    (wb_data),
        .i_raddr1   (w_rs),
        .o_rdata1   (w_rd1[b]),
        .i_raddr2   (w_rt),
        .o_rdata2   (w_rd2[b]),
        .i_dbg_addr (dbg_addr),
        .o_dbg_data (w_dbg[b])
      );
    end else begin : g_none
      assign w_rd1[b] = '0;
      assign w_rd2[b] = '0;
      assign w_dbg[b] = '0;
    end
  end

  assign dbg_data = dbg_bank ? w_dbg[1] : w_dbg[0];

  assign w_haz_rs = w_use_rs && r_rd == w_rs && r_bank == w_rs_bank && !(!w_rs_bank && w_rs == '0);
  assign w_haz_rt = w_use_rt && r_rd == w_rt && r_bank == w_rt_bank && !(!w_rt_bank && w_rt == '0);
  assign w_hazard = (HAZ_EN != 0) && r_valid && r_ctrl.mem_read && (w_haz_rs || w_haz_rt);
  assign if_ready = !rst && !flush && !w_hazard && (!r_valid || ex_ready);
  assign w_accept = if_valid && if_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_src1  <= '0;
      r_src2  <= '0;
      r_store <= '0;
      r_imm   <= '0;
      r_jaddr <= '0;
      r_rd    <= '0;
      r_bank  <= 1'b0;
      r_ctrl  <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (!r_valid || ex_ready) begin
      r_valid <= w_accept;
      if (w_accept) begin
        r_pc    <= if_pc;
        r_src1  <= w_rs_bank ? w_rd1[1] : w_rd1[0];
        r_src2  <= w_rt_bank ? w_rd2[1] : w_rd2[0];
        r_store <= w_rt_bank ? w_rd2[1] : w_rd2[0];
        r_imm   <= {{(XLEN-16){if_instr[15]}}, if_instr[15:0]};
        r_jaddr <= {if_pc[XLEN-1:28], if_instr[25:0], 2'b00};
        r_rd    <= w_dst;
        r_bank  <= w_dst_bank;
        r_ctrl  <= w_ctrl;
      end
    end
  end

  assign dx_valid      = r_valid;
  assign dx_pc         = r_pc;
  assign dx_src1       = r_src1;
  assign dx_src2       = r_src2;
  assign dx_store_data = r_store;
  assign dx_imm        = r_imm;
  assign dx_jump_addr  = r_jaddr;
  assign dx_rd_addr    = r_rd;
  assign dx_bank       = r_bank;
  assign dx_alu_ctrl   = r_valid ? r_ctrl.alu : 4'd0;
  assign dx_mem_read   = r_valid & r_ctrl.mem_read;
  assign dx_mem_write  = r_valid & r_ctrl.mem_write;
  assign dx_reg_write  = r_valid & r_ctrl.reg_write;
  assign dx_mem_to_reg = r_valid & r_ctrl.mem_to_reg;
  assign dx_branch     = r_valid & r_ctrl.branch;
  assign dx_jump       = r_valid & r_ctrl.jump;

endmodule
